mem_arbiter: RTL and testbench

//  Shares one single-ported word memory (combinational read, write on posedge clk) between the

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_picker.sv | 23 ++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the I/D memory arbiter
package mem_arb_pkg;

   localparam int WORD_LSB = 2;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   typedef enum logic {PORT_I, PORT_D} port_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      port_t       port;
      logic        err;
   } req_t;

   // Misaligned or beyond the last word: the access is answered but never issued
   function automatic logic addr_err(input logic [31:0] addr, input logic [31:WORD_LSB] depth);
      return (addr[WORD_LSB-1:0] != '0) || (addr[31:WORD_LSB] >= depth);
   endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// rtl/mem_arb_picker.sv - combinational grant between the fetch and load/store requesters
module mem_arb_picker
   import mem_arb_pkg::*;
(
   input  logic  i_valid,
   input  logic  d_valid,
   input  port_t prio,
   output logic  grant,
   output port_t grant_port
);

   // Sole requester wins; on a conflict the port named by prio wins
   always_comb begin
      grant      = i_valid | d_valid;
      grant_port = PORT_I;
      if (i_valid && d_valid) begin
         grant_port = prio;
      end else if (d_valid) begin
         grant_port = PORT_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D arbiter for one single-ported word memory; MEM_ARB_RR_EN selects round-robin
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   output logic        i_req_ready,
   input  logic [31:0] i_req_addr,
   output logic        i_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] i_rsp_rdata,
   output logic        i_rsp_err,
   input  logic        d_req_valid,
   output logic        d_req_ready,
   input  logic [31:0] d_req_addr,
   input  logic [31:0] d_req_wdata,
   input  logic        d_req_we,
   output logic        d_rsp_valid,
   input  logic        d_rsp_ready,
   output logic [31:0] d_rsp_rdata,
   output logic        d_rsp_err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write_enable,
   input  logic [31:0] mem_read_data
);

   localparam logic [31:WORD_LSB] DEPTH_LIM = (32-WORD_LSB)'(DEPTH_WORDS);

   state_t      state_q, state_d;
   req_t        req_q;
   port_t       prio, grant_port;
   logic        grant, accept, accept_window, rsp_hs;
   logic [31:0] in_addr, in_wdata, rdata_v;
   logic        in_we, in_err;

   mem_arb_picker u_picker (
      .i_valid    (i_req_valid),
      .d_valid    (d_req_valid),
      .prio       (prio),
      .grant      (grant),
      .grant_port (grant_port)
   );

`ifdef MEM_ARB_RR_EN
   port_t rr_ptr;

   // After each grant the other port gets priority on the next conflict
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= PORT_I;
      end else if (accept) begin
         rr_ptr <= (grant_port == PORT_I) ? PORT_D : PORT_I;
      end
   end

   assign prio = rr_ptr;
`else
   assign prio = PORT_D;
`endif

   // Select the granted request, classify it, and detect the response handshake
   always_comb begin
      in_addr  = (grant_port == PORT_D) ? d_req_addr : i_req_addr;
      in_wdata = (grant_port == PORT_D) ? d_req_wdata : '0;
      in_we    = (grant_port == PORT_D) & d_req_we;
      in_err   = addr_err(in_addr, DEPTH_LIM);
      rdata_v  = (req_q.we | req_q.err) ? '0 : mem_read_data;
      rsp_hs   = (req_q.port == PORT_I) ? (i_rsp_valid & i_rsp_ready)
                                        : (d_rsp_valid & d_rsp_ready);
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and request-side ready; a new request may overlap the response handshake
   always_comb begin
      state_d       = state_q;
      accept_window = 1'b0;
      accept        = 1'b0;
      i_req_ready   = 1'b0;
      d_req_ready   = 1'b0;
      case (state_q)
         IDLE:  accept_window = 1'b1;
         ISSUE: state_d = RESP;
         RESP: begin
            if (rsp_hs) begin
               accept_window = 1'b1;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (accept_window && grant && rst_n) begin
         accept      = 1'b1;
         state_d     = ISSUE;
         i_req_ready = (grant_port == PORT_I);
         d_req_ready = (grant_port == PORT_D);
      end
   end

   assign mem_address    = req_q.addr;
   assign mem_write_data = req_q.wdata;

   // Latch accepted requests, pulse the write in ISSUE, capture and retire responses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q            <= '0;
         mem_write_enable <= 1'b0;
         i_rsp_valid      <= 1'b0;
         i_rsp_rdata      <= '0;
         i_rsp_err        <= 1'b0;
         d_rsp_valid      <= 1'b0;
         d_rsp_rdata      <= '0;
         d_rsp_err        <= 1'b0;
      end else begin
         mem_write_enable <= 1'b0;
         if (rsp_hs) begin
            if (req_q.port == PORT_I) i_rsp_valid <= 1'b0;
            else                      d_rsp_valid <= 1'b0;
         end
         if (accept) begin
            req_q            <= '{addr: in_addr, wdata: in_wdata, we: in_we,
                                  port: grant_port, err: in_err};
            mem_write_enable <= in_we & ~in_err;
         end
         if (state_q == ISSUE) begin
            if (req_q.port == PORT_I) begin
               i_rsp_valid <= 1'b1;
               i_rsp_rdata <= rdata_v;
               i_rsp_err   <= req_q.err;
            end else begin
               d_rsp_valid <= 1'b1;
               d_rsp_rdata <= rdata_v;
               d_rsp_err   <= req_q.err;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (expects MEM_ARB_RR_EN to match the RTL build)
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready, i_rsp_err;
   logic [31:0] i_req_addr, i_rsp_rdata;
   logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
   logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
   logic        mem_write_enable;

   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];
   exp_t        exp_i_q[$];
   exp_t        exp_d_q[$];
   int          errors = 0;
   int          checks = 0;
   int          we_count = 0;

   mem_arbiter #(.DEPTH_WORDS(256)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_req_valid      (i_req_valid),
      .i_req_ready      (i_req_ready),
      .i_req_addr       (i_req_addr),
      .i_rsp_valid      (i_rsp_valid),
      .i_rsp_ready      (i_rsp_ready),
      .i_rsp_rdata      (i_rsp_rdata),
      .i_rsp_err        (i_rsp_err),
      .d_req_valid      (d_req_valid),
      .d_req_ready      (d_req_ready),
      .d_req_addr       (d_req_addr),
      .d_req_wdata      (d_req_wdata),
      .d_req_we         (d_req_we),
      .d_rsp_valid      (d_rsp_valid),
      .d_rsp_ready      (d_rsp_ready),
      .d_rsp_rdata      (d_rsp_rdata),
      .d_rsp_err        (d_rsp_err),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_write_enable (mem_write_enable),
      .mem_read_data    (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Attached single-ported memory: combinational read, write on posedge
   assign mem_read_data = mem[mem_address[9:2]];
   always @(posedge clk) begin
      if (mem_write_enable) mem[mem_address[9:2]] <= mem_write_data;
   end

   // Response monitor: pop and compare on every response handshake
   always @(negedge clk) begin
      exp_t e;
      if (mem_write_enable) we_count++;
      if (rst_n && i_rsp_valid && i_rsp_ready) begin
         checks++;
         if (exp_i_q.size() == 0) begin
            errors++;
            $display("FAIL i_rsp_unexpected rdata=%h err=%b", i_rsp_rdata, i_rsp_err);
         end else begin
            e = exp_i_q.pop_front();
            if (i_rsp_rdata !== e.rdata || i_rsp_err !== e.err) begin
               errors++;
               $display("FAIL i_rsp got rdata=%h err=%b want rdata=%h err=%b",
                        i_rsp_rdata, i_rsp_err, e.rdata, e.err);
            end
         end
      end
      if (rst_n && d_rsp_valid && d_rsp_ready) begin
         checks++;
         if (exp_d_q.size() == 0) begin
            errors++;
            $display("FAIL d_rsp_unexpected rdata=%h err=%b", d_rsp_rdata, d_rsp_err);
         end else begin
            e = exp_d_q.pop_front();
            if (d_rsp_rdata !== e.rdata || d_rsp_err !== e.err) begin
               errors++;
               $display("FAIL d_rsp got rdata=%h err=%b want rdata=%h err=%b",
                        d_rsp_rdata, d_rsp_err, e.rdata, e.err);
            end
         end
      end
   end

   task automatic push_expected(input port_t p, input logic [31:0] a,
                                input logic [31:0] wd, input logic we);
      exp_t e;
      logic err;
      err     = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
      e.err   = err;
      e.rdata = (err || we) ? 32'h0 : ref_mem[a[9:2]];
      if (we && !err) ref_mem[a[9:2]] = wd;
      if (p == PORT_I) exp_i_q.push_back(e);
      else             exp_d_q.push_back(e);
   endtask

   task automatic do_req(input port_t p, input logic [31:0] a,
                         input logic [31:0] wd, input logic we);
      logic done = 1'b0;
      if (p == PORT_I) begin
         i_req_valid = 1'b1; i_req_addr = a;
      end else begin
         d_req_valid = 1'b1; d_req_addr = a; d_req_wdata = wd; d_req_we = we;
      end
      for (int cyc = 0; cyc < 50 && !done; cyc++) begin
         @(negedge clk);
         if ((p == PORT_I) ? i_req_ready : d_req_ready) begin
            done = 1'b1;
            push_expected(p, a, wd, we);
         end
         @(posedge clk); #1;
      end
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL req_accept_timeout port=%0d addr=%h got=0 want=1", p, a);
      end
   endtask

   task automatic wait_drain();
      for (int cyc = 0; cyc < 50 && (exp_i_q.size() != 0 || exp_d_q.size() != 0); cyc++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (exp_i_q.size() != 0 || exp_d_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout pending_i=%0d pending_d=%0d want 0",
                  exp_i_q.size(), exp_d_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      i_req_valid = 1'b1; d_req_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, i_rsp_err, d_rsp_err,
           mem_write_enable} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags got=%b want=0000000", {i_req_ready, d_req_ready,
                  i_rsp_valid, d_rsp_valid, i_rsp_err, d_rsp_err, mem_write_enable});
      end
      checks++;
      if (i_rsp_rdata !== 32'h0 || d_rsp_rdata !== 32'h0 ||
          mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got i=%h d=%h addr=%h wdata=%h want all 0",
                  i_rsp_rdata, d_rsp_rdata, mem_address, mem_write_data);
      end
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_fetch();
      i_req_valid = 1'b1; i_req_addr = 32'h4;
      @(negedge clk);
      checks++;
      if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL fetch_ready got i=%b d=%b want i=1 d=0", i_req_ready, d_req_ready);
      end
      push_expected(PORT_I, 32'h4, 32'h0, 1'b0);
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (i_rsp_valid !== 1'b0 || mem_address !== 32'h4 || mem_write_enable !== 1'b0) begin
         errors++;
         $display("FAIL fetch_issue got rsp_valid=%b addr=%h we=%b want 0 00000004 0",
                  i_rsp_valid, mem_address, mem_write_enable);
      end
      @(negedge clk);
      checks++;
      if (i_rsp_valid !== 1'b1 || i_rsp_rdata !== 32'h12345678 || i_rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL fetch_rsp got valid=%b rdata=%h err=%b want 1 12345678 0",
                  i_rsp_valid, i_rsp_rdata, i_rsp_err);
      end
      wait_drain();
   endtask

   task automatic test_store_load();
      int we0;
      we0 = we_count;
      do_req(PORT_D, 32'h8, 32'hCAFEF00D, 1'b1);
      wait_drain();
      checks++;
      if (we_count - we0 != 1) begin
         errors++;
         $display("FAIL store_we_cycles got=%0d want=1", we_count - we0);
      end
      checks++;
      if (mem[2] !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL store_mem got=%h want=cafef00d", mem[2]);
      end
      do_req(PORT_D, 32'h8, 32'h0, 1'b0);
      wait_drain();
   endtask

   task automatic test_arbitration();
      port_t       order[4];
      int          n = 0;
      logic [31:0] ia = 32'h10;
      logic [31:0] da = 32'h20;
      i_req_valid = 1'b1; i_req_addr = ia;
      d_req_valid = 1'b1; d_req_addr = da; d_req_we = 1'b0;
      for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
         @(negedge clk);
         if (i_req_valid && i_req_ready) begin
            push_expected(PORT_I, ia, 32'h0, 1'b0);
            order[n] = PORT_I; n++; ia += 4;
         end else if (d_req_valid && d_req_ready) begin
            push_expected(PORT_D, da, 32'h0, 1'b0);
            order[n] = PORT_D; n++; da += 4;
         end
         @(posedge clk); #1;
         i_req_addr = ia; d_req_addr = da;
      end
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL arb_grants got=%0d want=4", n);
      end
`ifdef MEM_ARB_RR_EN
      for (int k = 1; k < n; k++) begin
         checks++;
         if (order[k] === order[k-1]) begin
            errors++;
            $display("FAIL arb_rr[%0d] got=%0d want=%0d", k, order[k], !order[k-1]);
         end
      end
`else
      for (int k = 0; k < n; k++) begin
         checks++;
         if (order[k] !== PORT_D) begin
            errors++;
            $display("FAIL arb_fixed[%0d] got=%0d want=%0d", k, order[k], PORT_D);
         end
      end
`endif
      wait_drain();
   endtask

   task automatic test_errors();
      int we0;
      we0 = we_count;
      do_req(PORT_D, 32'h6, 32'h11111111, 1'b1);
      do_req(PORT_D, 32'h400, 32'h22222222, 1'b1);
      do_req(PORT_I, 32'h401, 32'h0, 1'b0);
      wait_drain();
      checks++;
      if (we_count - we0 != 0) begin
         errors++;
         $display("FAIL err_we_cycles got=%0d want=0", we_count - we0);
      end
      checks++;
      if (mem[1] !== 32'h12345678) begin
         errors++;
         $display("FAIL err_mem1 got=%h want=12345678", mem[1]);
      end
   endtask

   task automatic test_backpressure();
      logic seen = 1'b0;
      d_rsp_ready = 1'b0;
      do_req(PORT_D, 32'h4, 32'h0, 1'b0);
      for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
         @(negedge clk);
         seen = d_rsp_valid;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL bp_rsp_timeout got=0 want=1");
      end
      @(posedge clk); #1;
      i_req_valid = 1'b1; i_req_addr = 32'hC;
      d_req_valid = 1'b1; d_req_addr = 32'h10; d_req_we = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== 32'h12345678 ||
             i_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d] got valid=%b rdata=%h iready=%b dready=%b want 1 12345678 0 0",
                     k, d_rsp_valid, d_rsp_rdata, i_req_ready, d_req_ready);
         end
         @(posedge clk); #1;
      end
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      d_rsp_ready = 1'b1;
      wait_drain();
   endtask

   task automatic test_reset_mid_store();
      d_req_valid = 1'b1; d_req_addr = 32'hC; d_req_wdata = 32'hDEADBEEF; d_req_we = 1'b1;
      @(negedge clk);
      checks++;
      if (d_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_store_accept got=%b want=1", d_req_ready);
      end
      @(posedge clk); #1;
      d_req_valid = 1'b0;
      checks++;
      if (mem_write_enable !== 1'b1 || mem_address !== 32'hC) begin
         errors++;
         $display("FAIL rst_store_issue got we=%b addr=%h want 1 0000000c",
                  mem_write_enable, mem_address);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (mem_write_enable !== 1'b0 || mem_address !== 32'h0 || mem_write_data !== 32'h0 ||
          d_rsp_valid !== 1'b0 || d_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_async got we=%b addr=%h wdata=%h rspv=%b rdy=%b want all 0",
                  mem_write_enable, mem_address, mem_write_data, d_rsp_valid, d_req_ready);
      end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (mem[3] !== 32'hA0000003 || d_rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_write got mem3=%h rspv=%b want a0000003 0", mem[3], d_rsp_valid);
      end
      do_req(PORT_I, 32'h4, 32'h0, 1'b0);
      wait_drain();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 32'hA0000000 + i;
         ref_mem[i] = 32'hA0000000 + i;
      end
      mem[1] = 32'h12345678; ref_mem[1] = 32'h12345678;
      i_req_valid = 1'b0; i_req_addr = 32'h0; i_rsp_ready = 1'b1;
      d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_wdata = 32'h0; d_req_we = 1'b0;
      d_rsp_ready = 1'b1;
      rst_n = 1'b0;

      test_reset();
      test_single_fetch();
      test_store_load();
      test_arbitration();
      test_errors();
      test_backpressure();
      test_reset_mid_store();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
